bcd_serial_display: RTL

//   Parametrised successor of the calculator's serial display driver. Captures a DIGITS-wide BCD word,

---
 rtl/calc_pkg.sv | 13 +
 rtl/ser_tick_gen.sv | 28 ++
 rtl/bcd_serial_display.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calculator display path.
package calc_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } dispState_t;

endpackage

// File: rtl/ser_tick_gen.sv
// Bit-rate prescaler: one tick every CLK_DIV enabled cycles, parked at zero while disabled.
module ser_tick_gen #(
    parameter int CLK_DIV = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/bcd_serial_display.sv
// Serial BCD display driver: blanks leading zeros, shifts a frame on ser_clk/ser_data,
// then strobes ser_latch. A one-deep pending buffer keeps the newest load requested while busy.
module bcd_serial_display
    import calc_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int CLK_DIV       = 2000,
    parameter int MSB_FIRST     = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BCD_W*DIGITS-1:0] bcd_in,
    input  logic                    load,
    output logic                    ser_clk,
    output logic                    ser_data,
    output logic                    ser_latch,
    output logic                    busy,
    output logic                    done
);

    localparam int FRAME_BITS = BCD_W * DIGITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    dispState_t            state;
    logic [FRAME_BITS-1:0] shiftReg;
    logic [FRAME_BITS-1:0] pendFrame;
    logic [FRAME_BITS-1:0] blanked;
    logic [FRAME_BITS-1:0] shifted;
    logic [FRAME_BITS-1:0] startFrame;
    logic                  pendValid;
    logic                  tick;
    logic [CNT_W-1:0]      bitCnt;

    // Walk down from the top digit; zeros stay blank until the first nonzero digit.
    function automatic logic [FRAME_BITS-1:0] blankLeading(input logic [FRAME_BITS-1:0] word);
        logic [FRAME_BITS-1:0] result;
        logic                  seen;
        result = word;
        seen   = 1'b0;
        for (int d = DIGITS - 1; d > 0; d--) begin
            if (word[d*BCD_W +: BCD_W] != '0) begin
                seen = 1'b1;
            end else if (!seen) begin
                result[d*BCD_W +: BCD_W] = BLANK_CODE;
            end
        end
        return result;
    endfunction

    function automatic logic firstBit(input logic [FRAME_BITS-1:0] word);
        return (MSB_FIRST != 0) ? word[FRAME_BITS-1] : word[0];
    endfunction

    assign blanked    = (BLANK_LEADING != 0) ? blankLeading(bcd_in) : bcd_in;
    assign shifted    = (MSB_FIRST != 0) ? (shiftReg << 1) : (shiftReg >> 1);
    assign startFrame = load ? blanked : pendFrame;

    ser_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) tickGen (
        .clk (clk),
        .rst (rst),
        .en  (state != IDLE),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shiftReg  <= '0;
            pendFrame <= '0;
            pendValid <= 1'b0;
            bitCnt    <= '0;
            ser_clk   <= 1'b0;
            ser_data  <= 1'b0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shiftReg <= blanked;
                        ser_data <= firstBit(blanked);
                        bitCnt   <= '0;
                        ser_clk  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (load) begin
                        pendFrame <= blanked;
                        pendValid <= 1'b1;
                    end
                    if (tick) begin
                        if (!ser_clk) begin
                            ser_clk <= 1'b1;
                        end else begin
                            ser_clk <= 1'b0;
                            if (bitCnt == LAST_BIT) begin
                                ser_data  <= 1'b0;
                                ser_latch <= 1'b1;
                                state     <= LATCH;
                            end else begin
                                bitCnt   <= bitCnt + CNT_W'(1);
                                shiftReg <= shifted;
                                ser_data <= firstBit(shifted);
                            end
                        end
                    end
                end
                LATCH: begin
                    // A load landing on the final latch cycle is the newest value, so it starts directly.
                    if (tick) begin
                        ser_latch <= 1'b0;
                        done      <= 1'b1;
                        if (load || pendValid) begin
                            shiftReg  <= startFrame;
                            ser_data  <= firstBit(startFrame);
                            bitCnt    <= '0;
                            pendValid <= 1'b0;
                            state     <= SHIFT;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (load) begin
                        pendFrame <= blanked;
                        pendValid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
